game_countdown_timer: RTL and testbench

- Consumes the slow toggling tick produced by the 1 Hz clock divider and turns it into the round countdown for the game.
- Synchronises the tick into the clk_25MHz domain and detects its rising edges.
- Decrements a seconds counter under a small start/pause/expire state machine.
- Drives BCD digits to the score/HUD renderer and a one-cycle expiry pulse to game control.

---
 rtl/game_countdown_timer_if.sv | 39 +++
 rtl/game_countdown_timer.sv | 155 +++++++++++++++
 tb/tb_game_countdown_timer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/game_countdown_timer_if.sv
// ----------------------------------------------------------------------------
// game_countdown_timer_if
// Groups the control inputs and HUD/game-control outputs of the round
// countdown timer.
//   tick_in        slow 1 Hz divider level (asynchronous to the timer clock)
//   start/pause    level controls; restart reloads the round time
//   seconds_left   remaining seconds, binary
//   bcd_tens/ones  decimal digits of seconds_left
//   running        timer is counting
//   expired_pulse  single-cycle strobe when the count reaches zero
//   time_up        round over
//   warn           low-time indicator
// Modports: master = game control / testbench side, slave = timer side.
// ----------------------------------------------------------------------------
interface game_countdown_timer_if;
    logic       tick_in;
    logic       start;
    logic       pause;
    logic       restart;
    logic [6:0] seconds_left;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       running;
    logic       expired_pulse;
    logic       time_up;
    logic       warn;

    modport master (
        output tick_in, start, pause, restart,
        input  seconds_left, bcd_tens, bcd_ones, running, expired_pulse,
               time_up, warn
    );

    modport slave (
        input  tick_in, start, pause, restart,
        output seconds_left, bcd_tens, bcd_ones, running, expired_pulse,
               time_up, warn
    );
endinterface

// File: rtl/game_countdown_timer.sv
// ----------------------------------------------------------------------------
// game_countdown_timer
// Turns the toggling 1 Hz divider output into the round countdown. The tick
// level is synchronised into clk_25MHz, its rising edges are detected, and a
// small start/pause/expire state machine decrements the seconds count.
// Ports:
//   clk_25MHz  system clock
//   reset      synchronous, active-high
//   bus        game_countdown_timer_if.slave (controls in, count/status out)
// Parameters:
//   START_SECONDS  count loaded on reset/restart (1..99)
//   WARN_SECONDS   warn threshold (0..99)
// Optional feature macro: GAME_TIMER_WARN_BLINK_EN
//   defined   : warn blinks (toggles per second) inside the warn window,
//               steady 1 once expired, held while paused
//   undefined : warn is a steady level, (seconds_left <= WARN_SECONDS) and
//               not idle
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | loaded, waiting for start; ticks ignored
// RUN   | counting down one per tick edge
// PAUSE | count frozen; start with pause low resumes
// DONE  | count is 0, time_up high; only restart/reset exit
// ----------------------------------------------------------------------------
module game_countdown_timer #(
    parameter int START_SECONDS = 60,
    parameter int WARN_SECONDS  = 10
) (
    input  logic                    clk_25MHz,
    input  logic                    reset,
    game_countdown_timer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [6:0] LP_START = 7'(START_SECONDS);
    localparam logic [6:0] LP_WARN  = 7'(WARN_SECONDS);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_s1, r_s2, r_s3;
    logic [6:0] r_secs;
    logic [6:0] w_secs_nxt;
    logic [3:0] r_tens, r_ones;
    logic       r_running;
    logic       r_expired;
    logic       w_expired_nxt;
    logic       r_time_up;
    logic       r_warn;
    logic       w_warn_nxt;
    logic       w_tick_edge;

    assign w_tick_edge = r_s2 & ~r_s3;

    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s3      <= 1'b0;
            r_state   <= ST_IDLE;
            r_secs    <= LP_START;
            r_tens    <= 4'(LP_START / 7'd10);
            r_ones    <= 4'(LP_START % 7'd10);
            r_running <= 1'b0;
            r_expired <= 1'b0;
            r_time_up <= 1'b0;
            r_warn    <= 1'b0;
        end else begin
            r_s1      <= bus.tick_in;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            r_state   <= w_state_nxt;
            r_secs    <= w_secs_nxt;
            // Digits come from the next count so they never lag the binary value.
            r_tens    <= 4'(w_secs_nxt / 7'd10);
            r_ones    <= 4'(w_secs_nxt % 7'd10);
            r_running <= (w_state_nxt == ST_RUN);
            r_expired <= w_expired_nxt;
            r_time_up <= (w_state_nxt == ST_DONE);
            r_warn    <= w_warn_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_secs_nxt    = r_secs;
        w_expired_nxt = 1'b0;
        w_warn_nxt    = r_warn;

        if (bus.restart) begin
            w_state_nxt = ST_IDLE;
            w_secs_nxt  = LP_START;
            w_warn_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!bus.pause && bus.start) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Pause beats a coincident tick: no decrement on that edge.
                    if (bus.pause) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (w_tick_edge) begin
                        if (r_secs > 7'd1) begin
                            w_secs_nxt = r_secs - 7'd1;
`ifdef GAME_TIMER_WARN_BLINK_EN
                            // Warn is 0 above the threshold, so the first
                            // toggle inside the window lands on 1.
                            if ((r_secs - 7'd1) <= LP_WARN) begin
                                w_warn_nxt = ~r_warn;
                            end
`endif
                        end else begin
                            w_secs_nxt    = 7'd0;
                            w_state_nxt   = ST_DONE;
                            w_expired_nxt = 1'b1;
`ifdef GAME_TIMER_WARN_BLINK_EN
                            w_warn_nxt    = 1'b1;
`endif
                        end
                    end
                end
                ST_PAUSE: begin
                    if (bus.start && !bus.pause) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_DONE;
                end
            endcase
        end

`ifndef GAME_TIMER_WARN_BLINK_EN
        w_warn_nxt = (w_secs_nxt <= LP_WARN) && (w_state_nxt != ST_IDLE);
`endif
    end

    assign bus.seconds_left  = r_secs;
    assign bus.bcd_tens      = r_tens;
    assign bus.bcd_ones      = r_ones;
    assign bus.running       = r_running;
    assign bus.expired_pulse = r_expired;
    assign bus.time_up       = r_time_up;
    assign bus.warn          = r_warn;

endmodule

// File: tb/tb_game_countdown_timer.sv
module tb_game_countdown_timer;

    localparam int START_A = 3;
    localparam int WARN_A  = 1;
    localparam int START_B = 60;
    localparam int WARN_B  = 10;
`ifdef GAME_TIMER_WARN_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    logic rst;
    logic tick, start, pause, restart;

    always #20 clk = ~clk;

    game_countdown_timer_if if_a ();
    game_countdown_timer_if if_b ();

    assign if_a.tick_in = tick;
    assign if_a.start   = start;
    assign if_a.pause   = pause;
    assign if_a.restart = restart;
    assign if_b.tick_in = tick;
    assign if_b.start   = start;
    assign if_b.pause   = pause;
    assign if_b.restart = restart;

    game_countdown_timer #(.START_SECONDS(START_A), .WARN_SECONDS(WARN_A)) dut_a (
        .clk_25MHz (clk),
        .reset     (rst),
        .bus       (if_a.slave)
    );

    game_countdown_timer #(.START_SECONDS(START_B), .WARN_SECONDS(WARN_B)) dut_b (
        .clk_25MHz (clk),
        .reset     (rst),
        .bus       (if_b.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a queue of the clock numbers at which each sampled
    // tick rise becomes effective, plus the round rules per timer instance.
    int cyc_n = 0;
    bit prev_tick = 1'b0;
    int due_q[$];
    int m_start[2] = '{START_A, START_B};
    int m_wthr[2]  = '{WARN_A, WARN_B};
    int m_secs[2];
    int m_mode[2];
    bit m_exp[2];
    bit m_warn[2];

    always @(posedge clk) begin
        bit tk;
        tk = 1'b0;
        cyc_n++;
        if (rst) begin
            due_q.delete();
            prev_tick = 1'b0;
        end else begin
            if (due_q.size() > 0 && due_q[0] == cyc_n) begin
                tk = 1'b1;
                void'(due_q.pop_front());
            end
            if (tick && !prev_tick) due_q.push_back(cyc_n + 2);
            prev_tick = tick;
        end
        for (int i = 0; i < 2; i++) begin
            m_exp[i] = 1'b0;
            if (rst || restart) begin
                m_secs[i] = m_start[i];
                m_mode[i] = M_IDLE;
                m_warn[i] = 1'b0;
            end else if (m_mode[i] == M_IDLE) begin
                if (!pause && start) m_mode[i] = M_RUN;
            end else if (m_mode[i] == M_RUN) begin
                if (pause) m_mode[i] = M_PAUSE;
                else if (tk) begin
                    m_secs[i] = m_secs[i] - 1;
                    if (m_secs[i] == 0) begin
                        m_mode[i] = M_DONE;
                        m_exp[i]  = 1'b1;
                        m_warn[i] = 1'b1;
                    end else if (m_secs[i] <= m_wthr[i]) begin
                        m_warn[i] = ((m_wthr[i] - m_secs[i]) % 2) == 0;
                    end
                end
            end else if (m_mode[i] == M_PAUSE) begin
                if (start && !pause) m_mode[i] = M_RUN;
            end
            if (!BLINK) m_warn[i] = (m_secs[i] <= m_wthr[i]) && (m_mode[i] != M_IDLE);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input string p, input int i, input logic [6:0] secs,
                           input logic [3:0] tens, input logic [3:0] ones,
                           input logic run, input logic expd, input logic tup,
                           input logic wrn);
        chk({p, "_secs"},    32'(secs), 32'(m_secs[i]));
        chk({p, "_tens"},    32'(tens), 32'(m_secs[i] / 10));
        chk({p, "_ones"},    32'(ones), 32'(m_secs[i] % 10));
        chk({p, "_running"}, 32'(run),  32'(m_mode[i] == M_RUN));
        chk({p, "_expired"}, 32'(expd), 32'(m_exp[i]));
        chk({p, "_time_up"}, 32'(tup),  32'(m_mode[i] == M_DONE));
        chk({p, "_warn"},    32'(wrn),  32'(m_warn[i]));
    endtask

    task automatic cyc();
        @(negedge clk);
        chk_dut("a", 0, if_a.seconds_left, if_a.bcd_tens, if_a.bcd_ones, if_a.running,
                if_a.expired_pulse, if_a.time_up, if_a.warn);
        chk_dut("b", 1, if_b.seconds_left, if_b.bcd_tens, if_b.bcd_ones, if_b.running,
                if_b.expired_pulse, if_b.time_up, if_b.warn);
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        repeat (4) cyc();
        tick = 1'b0;
        repeat (2) cyc();
    endtask

    initial begin
        int cnt;
        rst = 1'b1; tick = 1'b0; start = 1'b0; pause = 1'b0; restart = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        chk("rst_secs", 32'(if_a.seconds_left), 3);
        chk("rst_tens", 32'(if_a.bcd_tens), 0);
        chk("rst_ones", 32'(if_a.bcd_ones), 3);
        chk("rst_running", 32'(if_a.running), 0);
        chk("rst_time_up", 32'(if_a.time_up), 0);

        start = 1'b1; cyc(); start = 1'b0;
        chk("start_running", 32'(if_a.running), 1);

        // Decrement lands exactly three clocks after the tick rise.
        tick = 1'b1;
        cyc(); cyc();
        chk("lat_before", 32'(if_a.seconds_left), 3);
        cyc();
        chk("lat_after", 32'(if_a.seconds_left), 2);
        repeat (100) cyc();
        chk("hold_high", 32'(if_a.seconds_left), 2);
        tick = 1'b0; repeat (3) cyc();

        // Full expiry from 3.
        restart = 1'b1; cyc(); restart = 1'b0;
        chk("restart_load", 32'(if_a.seconds_left), 3);
        start = 1'b1; cyc(); start = 1'b0;
        repeat (2) tick_pulse();
        chk("two_ticks", 32'(if_a.seconds_left), 1);
        tick = 1'b1; cnt = 0;
        repeat (8) begin cyc(); cnt += int'(if_a.expired_pulse); end
        tick = 1'b0; cyc();
        chk("expire_secs", 32'(if_a.seconds_left), 0);
        chk("expire_pulses", 32'(cnt), 1);
        chk("expire_time_up", 32'(if_a.time_up), 1);
        tick_pulse();
        chk("done_no_wrap", 32'(if_a.seconds_left), 0);
        chk("done_time_up", 32'(if_a.time_up), 1);

        // Pause freezes the count.
        restart = 1'b1; cyc(); restart = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        tick_pulse();
        pause = 1'b1; cyc();
        repeat (2) tick_pulse();
        chk("pause_frozen", 32'(if_a.seconds_left), 2);
        chk("pause_running", 32'(if_a.running), 0);
        pause = 1'b0; start = 1'b1; cyc(); start = 1'b0;
        chk("resume_running", 32'(if_a.running), 1);
        tick_pulse();
        chk("resume_tick", 32'(if_a.seconds_left), 1);

        // Tick edge coincident with restart: reload wins, no expiry.
        tick = 1'b1; cyc(); cyc();
        restart = 1'b1; cyc(); restart = 1'b0;
        chk("coinc_secs", 32'(if_a.seconds_left), 3);
        chk("coinc_running", 32'(if_a.running), 0);
        chk("coinc_expired", 32'(if_a.expired_pulse), 0);
        tick = 1'b0; repeat (2) cyc();

        // Reset mid-count.
        start = 1'b1; cyc(); start = 1'b0;
        tick_pulse();
        chk("pre_reset", 32'(if_a.seconds_left), 2);
        rst = 1'b1; restart = 1'b1; cyc(); rst = 1'b0; restart = 1'b0;
        chk("mid_reset_secs", 32'(if_a.seconds_left), 3);
        chk("mid_reset_running", 32'(if_a.running), 0);

        // Warn behaviour on the 60-second instance.
        start = 1'b1; cyc(); start = 1'b0;
        repeat (49) tick_pulse();
        chk("warn_secs_11", 32'(if_b.seconds_left), 11);
        chk("warn_at_11", 32'(if_b.warn), 0);
        tick_pulse();
        chk("warn_at_10", 32'(if_b.warn), 1);
        tick_pulse();
        chk("warn_at_9", 32'(if_b.warn), BLINK ? 0 : 1);
        tick_pulse();
        chk("warn_secs_8", 32'(if_b.seconds_left), 8);
        chk("warn_at_8", 32'(if_b.warn), 1);
        chk("warn_bcd_tens", 32'(if_b.bcd_tens), 0);
        chk("warn_bcd_ones", 32'(if_b.bcd_ones), 8);

        // Randomised phase against the model.
        repeat (3000) begin
            if ($urandom_range(0, 5) == 0) tick = ~tick;
            start   = ($urandom_range(0, 3) == 0);
            pause   = ($urandom_range(0, 9) == 0);
            restart = ($urandom_range(0, 79) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
